// File: rtl/rom_case.sv
// 256 x 64-bit read-only lookup with a one-cycle registered read.
// Words 0x00-0x0F are programmed; every other address returns a marker pattern.
module rom_case (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  address,
  output logic [63:0] out
);

  localparam logic [63:0] DEFAULT_WORD = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam logic [63:0] RESET_WORD   = 64'h0000_0000_0000_0000;

  // Every address bit takes part in matching, so 0x1A and 0x0A do not alias.
  // An X/Z address matches no item and falls through to the default word.
  function automatic logic [63:0] rom_word(input logic [7:0] addr);
    logic [63:0] word;
    case (addr)
      8'h00:   word = 64'h0123_4567_89AB_CDEF;
      8'h01:   word = 64'h1111_1111_1111_1111;
      8'h02:   word = 64'h2222_2222_2222_2222;
      8'h03:   word = 64'h3333_3333_3333_3333;
      8'h04:   word = 64'h4444_4444_4444_4444;
      8'h05:   word = 64'h5555_5555_5555_5555;
      8'h06:   word = 64'h6666_6666_6666_6666;
      8'h07:   word = 64'h7777_7777_7777_7777;
      8'h08:   word = 64'h8888_8888_8888_8888;
      8'h09:   word = 64'h9999_9999_9999_9999;
      8'h0A:   word = 64'hAAAA_AAAA_AAAA_AAAA;
      8'h0B:   word = 64'hBBBB_BBBB_BBBB_BBBB;
      8'h0C:   word = 64'hCCCC_CCCC_CCCC_CCCC;
      8'h0D:   word = 64'hDDDD_DDDD_DDDD_DDDD;
      8'h0E:   word = 64'hEEEE_EEEE_EEEE_EEEE;
      8'h0F:   word = 64'hFFFF_FFFF_FFFF_FFFF;
      default: word = DEFAULT_WORD;
    endcase
    return word;
  endfunction

  // Stage p0: the only register; all-zero reset value is never a programmed word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      out <= RESET_WORD;
    else
      out <= rom_word(address);
  end

endmodule

// File: tb/tb_rom_case.sv
// Directed bench for rom_case: reset, programmed sweep, default region,
// mid-cycle address change, asynchronous reset pulse and a held address.
module tb_rom_case;

  logic        clk;
  logic        reset;
  logic [7:0]  address;
  logic [63:0] out;

  int checks;
  int failures;

  rom_case dut (
    .clk     (clk),
    .reset   (reset),
    .address (address),
    .out     (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] exp_word(input logic [7:0] a);
    logic [63:0] w;
    case (a)
      8'h00:   w = 64'h0123456789ABCDEF;
      8'h01:   w = 64'h1111111111111111;
      8'h02:   w = 64'h2222222222222222;
      8'h03:   w = 64'h3333333333333333;
      default: begin
        if (a < 8'h10) w = {16{a[3:0]}};
        else           w = 64'hDEADBEEFDEADBEEF;
      end
    endcase
    return w;
  endfunction

  initial begin
    logic [7:0] dflt [4];
    checks   = 0;
    failures = 0;
    dflt[0] = 8'h10; dflt[1] = 8'h1A; dflt[2] = 8'h80; dflt[3] = 8'hFF;

    // Reset held while clocking with address 0x05.
    reset   = 1'b1;
    address = 8'h05;
    #2;
    check_val("reset_immediate", out, 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("reset_held", out, 64'h0);
    end

    // Release between edges; first edge loads address 0x00.
    reset   = 1'b0;
    address = 8'h00;
    #1;
    check_val("after_release_pre_edge", out, 64'h0);
    for (int i = 0; i < 16; i++) begin
      address = 8'(i);
      tick();
      check_val($sformatf("sweep_%02h", i), out, exp_word(8'(i)));
    end

    // Unprogrammed region, including the aliasing candidate 0x1A.
    for (int i = 0; i < 4; i++) begin
      address = dflt[i];
      tick();
      check_val($sformatf("default_%02h", dflt[i]), out, 64'hDEADBEEFDEADBEEF);
    end

    // Address change between edges must not reach out until the next edge.
    address = 8'h03;
    tick();
    check_val("hold_03", out, 64'h3333333333333333);
    #2 address = 8'h07;
    #1;
    check_val("between_edges_03", out, 64'h3333333333333333);
    tick();
    check_val("load_07", out, 64'h7777777777777777);

    // Asynchronous reset pulse between edges.
    address = 8'h0C;
    tick();
    check_val("pre_pulse_0c", out, 64'hCCCCCCCCCCCCCCCC);
    #1 reset = 1'b1;
    #1;
    check_val("async_clear", out, 64'h0);
    reset = 1'b0;
    #1;
    check_val("cleared_before_edge", out, 64'h0);
    tick();
    check_val("reload_0c", out, 64'hCCCCCCCCCCCCCCCC);

    // Held address must give a constant output.
    address = 8'h0E;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val($sformatf("hold_0e_%0d", i), out, 64'hEEEEEEEEEEEEEEEE);
      #3;
      check_val($sformatf("hold_0e_mid_%0d", i), out, 64'hEEEEEEEEEEEEEEEE);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
